pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Replaces fixed per-stage registers (ID/EX, EX/MEM, MEM/WB) with one block.
//  Adds per-stage stall (downstream backpressure), synchronous flush and bubble insertion.
//  in_ready is fully registered, so upstream stall logic has no combinational path from out_ready.
//  Payload is split into CTRL (zeroed on bubble/flush) and DATA (zeroed only if CLR_DATA=1).
// PARAMETERS
//  CTRL_W    7    control-field width (EX/MEM: MemtoReg[1:0],Jump,Branch,MemRead,MemWrite,RegWrite)
//  DATA_W    102  data-field width (EX/MEM: PC_beq,alu_result,ReadData2 32b each; zero 1b; WriteReg 5b)
//  CLR_DATA  0    1: out_data and skid data are also cleared to 0 on flush; 0: data is held
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  flush      in   1       synchronous squash of all held entries (branch/jump redirect)
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       block can accept (registered)
//  in_ctrl    in   CTRL_W  upstream control field
//  in_data    in   DATA_W  upstream data field
//  out_valid  out  1       out_ctrl/out_data hold a valid entry
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_ctrl   out  CTRL_W  registered control; all-zero whenever out_valid=0
//  out_data   out  DATA_W  registered data
//  occupancy  out  2       entries held: 0,1,2 (out reg + skid reg)
// BEHAVIOUR
//  - Reset (async): out_valid=0, skid_valid=0, out_ctrl=0, out_data=0, skid regs=0, in_ready=1, occupancy=0.
//  - accept = in_valid & in_ready; drain = out_valid & out_ready.
//  - Latency 1 cycle in to out with empty skid; sustained throughput 1 entry/cycle when out_ready=1.
//  - Next-state per clock, in priority order:
//    1. flush=1: out_valid<=0, skid_valid<=0, out_ctrl<=0 (bubble), in_ready<=1; the input offered in
//       this cycle is dropped even if in_valid=1; data cleared only if CLR_DATA=1.
//    2. out reg empty or drain: load out from skid if skid_valid (skid_valid<=0), else from input if
//       accept; if skid loaded and accept, input goes to skid (skid_valid stays 1); nothing to load -> out_valid<=0.
//    3. out full, no drain, accept: input written to skid, skid_valid<=1.
//    4. otherwise hold.
//  - in_ready <= ~next skid_valid; never asserted while skid full, so no entry is ever overwritten.
//  - Ordering strictly FIFO: skid entry always leaves before any later input.
//  - out_ctrl forced 0 on any cycle out_valid becomes 0 (bubble -> no RegWrite/MemWrite downstream).
//  - occupancy = out_valid + skid_valid; never exceeds 2.
//  - Reset mid-transfer: entries discarded, no partial state retained.
//  - Simultaneous flush and out_ready=1: downstream consumes the current out entry this edge; still squashed next.
// STRUCTURE
//  - Shared package pipe_pkg: EX_MEM_CTRL_W=7, EX_MEM_DATA_W=102, field-offset localparams for
//    ctrl bits and data fields; packed struct typedefs ex_mem_ctrl_t / ex_mem_data_t for pack/unpack.
//  - No sub-module: two register entries plus next-state logic in one module; callers pack/unpack fields.
// TESTING
//  - Reset: reset=1 mid-stream with occupancy=2 -> immediately out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
//  - Stream: in_valid=1 for 8 cycles, out_ready=1, data 0..7 -> out_data 0..7 one cycle later, no gaps.
//  - Stall: 3 entries A,B,C offered, out_ready=0 from cycle 1 -> A held in out, B in skid,
//    in_ready=0 from cycle 3, C held upstream; out_ready=1 -> A,B,C in order, no loss or duplicate.
//  - Flush: occupancy=2, flush=1 with in_valid=1 ctrl=7'h7F -> next cycle out_valid=0, out_ctrl=0,
//    occupancy=0, in_ready=1; flushed-cycle input never appears at output.
//  - Bubble: in_valid=0 one cycle in stream with RegWrite=1 -> one cycle out_valid=0, out_ctrl=7'h00.
//  - CLR_DATA=1 build: flush with out_data=32'hDEADBEEF-filled -> out_data=0; CLR_DATA=0 -> data held.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared widths, field offsets and packed layouts for the
//                EX/MEM inter-stage payload carried by pipe_stage_skid.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int EX_MEM_CTRL_W = 7;
   localparam int EX_MEM_DATA_W = 102;

   // Control-field bit positions (MSB first: MemtoReg[1:0],Jump,Branch,MemRead,MemWrite,RegWrite)
   localparam int CTRL_REGWRITE     = 0;
   localparam int CTRL_MEMWRITE     = 1;
   localparam int CTRL_MEMREAD      = 2;
   localparam int CTRL_BRANCH       = 3;
   localparam int CTRL_JUMP         = 4;
   localparam int CTRL_MEMTOREG_LSB = 5;
   localparam int CTRL_MEMTOREG_MSB = 6;

   // Data-field offsets (MSB first: PC_beq, alu_result, ReadData2, zero, WriteReg)
   localparam int DATA_WORD_W       = 32;
   localparam int DATA_WRITEREG_LSB = 0;
   localparam int DATA_WRITEREG_W   = 5;
   localparam int DATA_ZERO_BIT     = 5;
   localparam int DATA_RD2_LSB      = 6;
   localparam int DATA_ALU_LSB      = 38;
   localparam int DATA_PCBEQ_LSB    = 70;

   typedef struct packed {
      logic [1:0] mem_to_reg;
      logic       jump;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
   } ex_mem_ctrl_t;

   typedef struct packed {
      logic [31:0] pc_beq;
      logic [31:0] alu_result;
      logic [31:0] read_data2;
      logic        zero;
      logic [4:0]  write_reg;
   } ex_mem_data_t;

   function automatic ex_mem_ctrl_t unpack_ctrl(input logic [EX_MEM_CTRL_W-1:0] v);
      return ex_mem_ctrl_t'(v);
   endfunction

   function automatic ex_mem_data_t unpack_data(input logic [EX_MEM_DATA_W-1:0] v);
      return ex_mem_data_t'(v);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Inter-stage pipeline register with valid/ready handshake and
//                a one-entry skid buffer behind the output register. in_ready
//                is registered so upstream stall logic never sees out_ready
//                combinationally. Supports flush and bubble insertion.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W   = EX_MEM_CTRL_W,
   parameter int DATA_W   = EX_MEM_DATA_W,
   parameter bit CLR_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              out_valid_q,  out_valid_d;
   logic [CTRL_W-1:0] out_ctrl_q,   out_ctrl_d;
   logic [DATA_W-1:0] out_data_q,   out_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic              in_ready_q,   in_ready_d;

   logic w_accept;
   logic w_drain;

   assign w_accept = in_valid & in_ready_q;
   assign w_drain  = out_valid_q & out_ready;

   // Next-state selection: flush, then refill of an empty/draining output, then skid capture.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_ctrl_d   = out_ctrl_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;

      if (flush) begin
         // The entry offered this cycle is dropped; both slots become bubbles.
         out_valid_d  = 1'b0;
         out_ctrl_d   = '0;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = '0;
         if (CLR_DATA) begin
            out_data_d  = '0;
            skid_data_d = '0;
         end
      end else if (!out_valid_q || w_drain) begin
         if (skid_valid_q) begin
            // Older skid entry always leaves first to keep FIFO order.
            out_valid_d  = 1'b1;
            out_ctrl_d   = skid_ctrl_q;
            out_data_d   = skid_data_q;
            skid_valid_d = w_accept;
            if (w_accept) begin
               skid_ctrl_d = in_ctrl;
               skid_data_d = in_data;
            end
         end else if (w_accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            out_data_d  = in_data;
         end else begin
            // Bubble: control is zeroed so no stray RegWrite/MemWrite downstream.
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
         end
      end else if (w_accept) begin
         skid_valid_d = 1'b1;
         skid_ctrl_d  = in_ctrl;
         skid_data_d  = in_data;
      end

      in_ready_d = ~skid_valid_d;
   end

   // Output/skid registers and registered ready, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_ctrl_q   <= '0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_ctrl_q   <= out_ctrl_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_data  = out_data_q;
   assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Scoreboard bench for pipe_stage_skid (CLR_DATA=0 and =1).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int CW = EX_MEM_CTRL_W;
   localparam int DW = EX_MEM_DATA_W;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          in_ready, out_valid;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
   logic          clr_in_ready, clr_out_valid;
   logic [CW-1:0] clr_out_ctrl;
   logic [DW-1:0] clr_out_data;
   logic [1:0]    clr_occupancy;

   int   n_checks = 0;
   int   n_pass   = 0;
   ent_t sb[$];

   always #5 clk = ~clk;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b0)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy)
   );

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b1)) dut_clr (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(clr_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(clr_out_valid), .out_ready(out_ready), .out_ctrl(clr_out_ctrl), .out_data(clr_out_data),
      .occupancy(clr_occupancy)
   );

   // Sample handshake before the edge, update the scoreboard, then advance one clock.
   task automatic tick(output bit acc, output bit got, output ent_t ex, output ent_t ac);
      acc = in_valid && in_ready && !flush;
      got = out_valid && out_ready;
      ac  = {out_ctrl, out_data};
      ex  = '0;
      if (got) begin
         if (sb.size() > 0) ex = sb.pop_front();
         else               ex = ~ac;
      end
      if (flush)    sb.delete();
      else if (acc) sb.push_back({in_ctrl, in_data});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if ({out_valid, out_ctrl, in_ready, occupancy} !== {1'b0, 7'h00, 1'b1, 2'd0})
         $display("FAIL reset_state: got v=%b c=%h r=%b occ=%0d", out_valid, out_ctrl, in_ready, occupancy);
      else n_pass++;
      n_checks++; if (out_data !== '0) $display("FAIL reset_data: got %h required 0", out_data);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_stream();
      bit acc, got; ent_t ex, ac;
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = (i < 8);
         in_ctrl  = 7'h01;
         in_data  = DW'(i);
         tick(acc, got, ex, ac);
         n_checks++; if (got !== (i > 0)) $display("FAIL stream_nogap[%0d]: drain=%b required %b", i, got, (i > 0));
         else n_pass++;
         if (got) begin
            n_checks++; if (ac !== ex) $display("FAIL stream_data[%0d]: got %h required %h", i, ac, ex);
            else n_pass++;
         end
      end
      n_checks++; if (sb.size() != 0) $display("FAIL stream_left: %0d entries still pending, required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_stall();
      bit acc, got; ent_t ex, ac;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl = 7'h01; in_data = DW'(32'hA);
      tick(acc, got, ex, ac);
      in_ctrl = 7'h02; in_data = DW'(32'hB);
      tick(acc, got, ex, ac);
      n_checks++; if ({occupancy, in_ready} !== {2'd2, 1'b0})
         $display("FAIL stall_full: got occ=%0d ready=%b required occ=2 ready=0", occupancy, in_ready);
      else n_pass++;
      in_ctrl = 7'h03; in_data = DW'(32'hC);
      for (int k = 0; k < 3; k++) begin
         tick(acc, got, ex, ac);
         n_checks++; if ({acc, got, out_data} !== {1'b0, 1'b0, DW'(32'hA)})
            $display("FAIL stall_hold[%0d]: got acc=%b drain=%b data=%h required 0 0 A", k, acc, got, out_data);
         else n_pass++;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 8 && (in_valid || sb.size() > 0); k++) begin
         tick(acc, got, ex, ac);
         if (acc) in_valid = 1'b0;
         if (got) begin
            n_checks++; if (ac !== ex) $display("FAIL stall_order: got %h required %h", ac, ex);
            else n_pass++;
         end
      end
      n_checks++; if ({in_valid, sb.size() == 0, occupancy} !== {1'b0, 1'b1, 2'd0})
         $display("FAIL stall_drain: got pending_in=%b left=%0d occ=%0d required 0 0 0", in_valid, sb.size(), occupancy);
      else n_pass++;
   endtask

   task automatic test_flush();
      bit acc, got; ent_t ex, ac;
      logic [DW-1:0] fill_a;
      fill_a    = {6'h3F, {3{32'hDEADBEEF}}};
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl = 7'h01; in_data = fill_a;
      tick(acc, got, ex, ac);
      in_ctrl = 7'h02; in_data = ~fill_a;
      tick(acc, got, ex, ac);
      n_checks++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d required 2", occupancy);
      else n_pass++;
      flush = 1'b1; in_ctrl = 7'h7F; in_data = DW'(32'h1234_5678);
      tick(acc, got, ex, ac);
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 7'h00, 2'd0, 1'b1})
         $display("FAIL flush_state: got v=%b c=%h occ=%0d r=%b required 0 00 0 1", out_valid, out_ctrl, occupancy, in_ready);
      else n_pass++;
      n_checks++; if (out_data !== fill_a) $display("FAIL flush_data_held: got %h required %h", out_data, fill_a);
      else n_pass++;
      n_checks++; if ({clr_out_data, clr_out_valid, clr_occupancy} !== {DW'(0), 1'b0, 2'd0})
         $display("FAIL flush_data_clr: got %h v=%b occ=%0d required 0", clr_out_data, clr_out_valid, clr_occupancy);
      else n_pass++;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(acc, got, ex, ac);
         n_checks++; if (got !== 1'b0) $display("FAIL flush_ghost[%0d]: got output %h required none", k, ac);
         else n_pass++;
      end
      // Flush together with out_ready: current out entry is still consumed.
      out_ready = 1'b0; in_valid = 1'b1;
      in_ctrl = 7'h05; in_data = DW'(32'h55);
      tick(acc, got, ex, ac);
      in_ctrl = 7'h06; in_data = DW'(32'h66);
      tick(acc, got, ex, ac);
      flush = 1'b1; out_ready = 1'b1; in_ctrl = 7'h7F;
      tick(acc, got, ex, ac);
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if ({got, ac} !== {1'b1, ex}) $display("FAIL flush_consume: got drain=%b %h required 1 %h", got, ac, ex);
      else n_pass++;
      n_checks++; if ({out_valid, occupancy, clr_in_ready} !== {1'b0, 2'd0, 1'b1})
         $display("FAIL flush_consume_after: got v=%b occ=%0d clr_ready=%b required 0 0 1", out_valid, occupancy, clr_in_ready);
      else n_pass++;
   endtask

   task automatic test_bubble();
      bit acc, got; ent_t ex, ac;
      bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_valid = pat[k];
         in_ctrl  = 7'h01;
         in_data  = DW'(100 + k);
         tick(acc, got, ex, ac);
         if (got) begin
            n_checks++; if (ac !== ex) $display("FAIL bubble_data[%0d]: got %h required %h", k, ac, ex);
            else n_pass++;
         end
         n_checks++; if ({out_valid, out_ctrl} !== {pat[k], (pat[k] ? 7'h01 : 7'h00)})
            $display("FAIL bubble_out[%0d]: got v=%b c=%h required v=%b", k, out_valid, out_ctrl, pat[k]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      bit acc, got; ent_t ex, ac;
      for (int k = 0; k < 300; k++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         in_ctrl   = CW'($urandom);
         in_data   = {6'($urandom), $urandom, $urandom, $urandom};
         n_checks++; if ({occupancy, in_ready} !== {2'(sb.size()), (sb.size() < 2)})
            $display("FAIL rand_occ[%0d]: got occ=%0d r=%b model %0d", k, occupancy, in_ready, sb.size());
         else n_pass++;
         tick(acc, got, ex, ac);
         if (got) begin
            n_checks++; if (ac !== ex) $display("FAIL rand_data[%0d]: got %h required %h", k, ac, ex);
            else n_pass++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 5 && sb.size() > 0; k++) begin
         tick(acc, got, ex, ac);
         if (got) begin
            n_checks++; if (ac !== ex) $display("FAIL rand_tail: got %h required %h", ac, ex);
            else n_pass++;
         end
      end
      n_checks++; if (sb.size() != 0) $display("FAIL rand_left: %0d entries never emerged, required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      bit acc, got; ent_t ex, ac;
      out_ready = 1'b0; in_valid = 1'b1;
      in_ctrl = 7'h01; in_data = DW'(32'h11);
      tick(acc, got, ex, ac);
      in_data = DW'(32'h22);
      tick(acc, got, ex, ac);
      in_valid = 1'b0;
      n_checks++; if (occupancy !== 2'd2) $display("FAIL midrst_pre_occ: got %0d required 2", occupancy);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++; if ({out_valid, out_ctrl, in_ready, occupancy} !== {1'b0, 7'h00, 1'b1, 2'd0})
         $display("FAIL midrst_state: got v=%b c=%h r=%b occ=%0d", out_valid, out_ctrl, in_ready, occupancy);
      else n_pass++;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1;
      in_ctrl = 7'h01; in_data = DW'(32'h99);
      tick(acc, got, ex, ac);
      in_valid = 1'b0;
      tick(acc, got, ex, ac);
      n_checks++; if ({got, ac} !== {1'b1, ex}) $display("FAIL midrst_after: got drain=%b %h required 1 %h", got, ac, ex);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_bubble();
      test_random();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
